// File: rtl/ring_freq_meter.sv
// ring_freq_meter
//
// Gated edge counter for reading divided ring-oscillator taps as numbers.
// One of NCH asynchronous taps is selected, synchronised and its rising
// edges are counted over a programmable window of clk cycles. The result is
// offered with a valid/ack handshake.
//
// Ports:
//   clk       system clock, all state updates on its rising edge
//   rst       synchronous active-high reset
//   osc_in    NCH oscillator/divider taps, asynchronous to clk
//   ch_sel    channel to measure, captured on an accepted start
//   gate_len  window length in clk cycles, captured on an accepted start
//   start     measurement request, honoured only when idle
//   ack       result acknowledge, honoured only while valid
//   busy      measurement in progress (arming or counting)
//   valid     result available; count/overflow stable while high
//   count     rising edges seen in the window (saturating)
//   overflow  counter hit all-ones and lost at least one edge
module ring_freq_meter #(
  parameter int NCH    = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    osc_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              ack,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PAD_W = 2 ** SEL_W;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ch_q;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  gate_cnt;
  logic [1:0]         arm_cnt;
  logic [PAD_W-1:0]   osc_pad;
  logic               tap;
  logic               sync_p0;
  logic               sync_p1;
  logic               sync_p2;
  logic               rise;

  // Unused select codes read zero-padded taps, so an out-of-range channel
  // simply measures a constant-low input.
  always_comb begin
    osc_pad = '0;
    osc_pad[NCH-1:0] = osc_in;
  end

  assign tap  = osc_pad[ch_q];
  assign rise = sync_p1 & ~sync_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_q     <= '0;
      gate_q   <= '0;
      gate_cnt <= '0;
      arm_cnt  <= '0;
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // p0/p1: two-flop synchroniser; p2: previous level for edge detection
      sync_p0 <= tap;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;

      case (state)
        IDLE: begin
          if (start) begin
            ch_q     <= ch_sel;
            gate_q   <= gate_len;
            count    <= '0;
            overflow <= 1'b0;
            arm_cnt  <= '0;
            busy     <= 1'b1;
            state    <= ARM;
          end
        end

        // Three cycles let the synchroniser drain the previous channel's
        // history, so the first counted edge belongs to the new channel.
        ARM: begin
          if (arm_cnt == 2'd2) begin
            if (gate_q != '0) begin
              gate_cnt <= gate_q;
              state    <= MEASURE;
            end else begin
              busy  <= 1'b0;
              valid <= 1'b1;
              state <= DONE;
            end
          end else begin
            arm_cnt <= arm_cnt + 2'd1;
          end
        end

        MEASURE: begin
          if (rise) begin
            if (count == '1) begin
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          if (gate_cnt == GATE_W'(1)) begin
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end

        DONE: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Testbench for ring_freq_meter: oscillator taps are generated as periodic
// waveforms defined per clk sample; the expected edge count for each window
// is computed from those waveforms and queued for a monitor that checks each
// result when valid rises.
module tb_ring_freq_meter;

  localparam int NCH    = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;
  localparam int GATE_W = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    osc_in = '0;
  logic [SEL_W-1:0]  ch_sel = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              start = 1'b0;
  logic              ack = 1'b0;
  logic              busy;
  logic              valid;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  ring_freq_meter #(
    .NCH(NCH), .SEL_W(SEL_W), .CNT_W(CNT_W), .GATE_W(GATE_W)
  ) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .ch_sel(ch_sel),
    .gate_len(gate_len), .start(start), .ack(ack), .busy(busy),
    .valid(valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // cyc = index of the next rising edge whenever read away from posedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tap waveforms: level at edge c is ((c+ph) mod per) < hi; per<2 means low.
  int per[NCH];
  int hi[NCH];
  int ph[NCH];

  function automatic logic lvl(input int ch, input int c);
    if (ch >= NCH) return 1'b0;
    if (per[ch] < 2) return 1'b0;
    return ((c + ph[ch]) % per[ch]) < hi[ch];
  endfunction

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NCH; k++) osc_in[k] = lvl(k, cyc);
  end

  typedef struct {
    int c;
    bit o;
    int t;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every result as it appears and while it is held.
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (valid && !vprev) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got valid=1, expected no result (cycle %0d)", cyc);
        end else begin
          cur = sbq.pop_front();
          chk("count", int'(count), cur.c);
          chk("overflow", int'(overflow), int'(cur.o));
          chk("valid_cycle", cyc, cur.t);
          chk("busy_in_done", int'(busy), 0);
        end
      end else if (valid) begin
        chk("count_held", int'(count), cur.c);
        chk("overflow_held", int'(overflow), int'(cur.o));
      end
      vprev = valid;
    end
  end

  // Rising edges of the chosen tap that become visible at samples
  // T+2..T+1+g fall inside the window of a start accepted at edge T.
  task automatic issue(input int ch, input int g);
    int   t0;
    int   n;
    exp_t e;
    t0 = cyc;
    n  = 0;
    for (int j = t0 + 2; j <= t0 + 1 + g; j++)
      if (lvl(ch, j) && !lvl(ch, j - 1)) n++;
    e.c = (n > CMAX) ? CMAX : n;
    e.o = (n > CMAX);
    e.t = t0 + 4 + g;
    sbq.push_back(e);
    ch_sel   = SEL_W'(ch);
    gate_len = GATE_W'(g);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    gate_len = GATE_W'($urandom);
    ch_sel   = SEL_W'($urandom);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_meas(input int ch, input int g, input int hold, input bit noise);
    int i;
    issue(ch, g);
    i = 0;
    while (!valid && i < 400) begin
      if (noise && busy) begin
        start    = 1'($urandom % 2);
        ack      = 1'($urandom % 2);
        gate_len = GATE_W'($urandom);
        ch_sel   = SEL_W'($urandom);
      end else begin
        start = 1'b0;
        ack   = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    ack   = 1'b0;
    if (!valid) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got no valid in 400 cycles, expected valid (cycle %0d)", cyc);
      sbq.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("valid_held", int'(valid), 1);
      if (noise) begin
        start    = 1'($urandom % 2);
        gate_len = GATE_W'($urandom);
      end
      @(negedge clk);
    end
    ack   = 1'b1;
    start = noise ? 1'($urandom % 2) : 1'b0;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    chk("valid_after_ack", int'(valid), 0);
    chk("busy_after_ack", int'(busy), 0);
    chk("count_kept_idle", int'(count), cur.c);
  endtask

  task automatic set_osc(input int k, input int p, input int h, input int f);
    per[k] = p;
    hi[k]  = h;
    ph[k]  = f;
  endtask

  initial begin
    // Reset held with taps toggling and start asserted
    for (int k = 0; k < NCH; k++) set_osc(k, 2, 1, k);
    rst      = 1'b1;
    start    = 1'b1;
    ch_sel   = 2'd1;
    gate_len = 8'd5;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_overflow", int'(overflow), 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(valid), 0);

    // Period-4 tap on channel 1, rising at T+1+4k, 40-cycle window
    for (int k = 0; k < NCH; k++) set_osc(k, 0, 1, 0);
    set_osc(1, 4, 2, (4 - ((cyc + 1) % 4)) % 4);
    run_meas(1, 40, 5, 1'b0);

    // Channel isolation and out-of-range select
    set_osc(0, 2, 1, 0);
    set_osc(1, 0, 1, 0);
    run_meas(2, 30, 1, 1'b0);
    for (int k = 0; k < NCH; k++) set_osc(k, 2, 1, 0);
    run_meas(3, 20, 1, 1'b0);

    // Saturation, then a short window that must clear overflow
    run_meas(0, 40, 2, 1'b0);
    run_meas(0, 8, 1, 1'b0);

    // Zero gate, and windows disturbed by ignored start/ack/gate_len activity
    run_meas(1, 0, 1, 1'b1);
    set_osc(1, 5, 2, 3);
    run_meas(1, 25, 3, 1'b1);

    // Reset in the middle of a 40-cycle window
    set_osc(2, 3, 1, 1);
    issue(2, 40);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_overflow", int'(overflow), 0);
    sbq.delete();
    run_meas(2, 12, 1, 1'b0);

    // Randomised tap shapes, channels and windows
    repeat (15) begin
      for (int k = 0; k < NCH; k++) begin
        int p;
        p = int'($urandom_range(0, 7));
        set_osc(k, p, (p >= 2) ? int'($urandom_range(1, p - 1)) : 1, int'($urandom_range(0, 7)));
      end
      run_meas(int'($urandom_range(0, 3)), int'($urandom_range(0, 45)),
               int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected end of run (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
